// File: rtl/hwag_capture_period.sv
// Multi-channel VR/hall input capture: sync, glitch filter, edge select
// and period timer with strobed result and sticky overflow.
module hwag_capture_period #(
  parameter int CH = 2,
  parameter int FW = 16,
  parameter int PW = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    ena,
  input  logic [2*CH-1:0]  mode,
  input  logic [CH*FW-1:0] flt_val,
  input  logic [CH-1:0]    ovf_clr,
  input  logic [CH-1:0]    d,
  output logic [CH-1:0]    filtered,
  output logic [CH-1:0]    edge_stb,
  output logic [CH*PW-1:0] period,
  output logic [CH-1:0]    period_vld,
  output logic [CH-1:0]    ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  localparam logic [PW-1:0] PC_ONE = PW'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          flt;
    logic          flt_q;
    logic          stb;
    logic [FW-1:0] fc;
    logic [FW-1:0] thr;
    logic [1:0]    md;
    logic          en;
    logic          go;
    logic          rise;
    logic          fall;

    state_t        st;
    state_t        st_nx;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_nx;
    logic [PW-1:0] per;
    logic [PW-1:0] per_nx;
    logic          vld;
    logic          vld_nx;
    logic          of;
    logic          of_nx;

    assign thr  = flt_val[FW*i +: FW];
    assign md   = mode[2*i +: 2];
    assign en   = ena[i];
    assign go   = en & (|md);
    assign rise = flt & ~flt_q;
    assign fall = ~flt & flt_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        flt <= 1'b0;
        fc  <= '0;
      end else begin
        s1 <= d[i];
        s2 <= s1;
        if (!en) begin
          fc <= '0;
        end else if (s2 == flt) begin
          fc <= '0;
        end else if (fc == thr) begin
          flt <= s2;
          fc  <= '0;
        end else begin
          fc <= fc + FW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        flt_q <= 1'b0;
        stb   <= 1'b0;
      end else begin
        flt_q <= flt;
        stb   <= en & ((rise & md[0]) | (fall & md[1]));
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        st  <= IDLE;
        pc  <= '0;
        per <= '0;
        vld <= 1'b0;
        of  <= 1'b0;
      end else begin
        st  <= st_nx;
        pc  <= pc_nx;
        per <= per_nx;
        vld <= vld_nx;
        of  <= of_nx;
      end
    end

    // Overflow set is evaluated after the clear so a coincident set wins.
    always_comb begin
      st_nx  = st;
      pc_nx  = pc;
      per_nx = per;
      vld_nx = 1'b0;
      of_nx  = of;
      if (ovf_clr[i]) of_nx = 1'b0;
      if (!go) begin
        st_nx = IDLE;
        pc_nx = '0;
      end else begin
        case (st)
          IDLE: begin
            st_nx = ARM;
            pc_nx = '0;
          end
          ARM: begin
            if (stb) begin
              st_nx = RUN;
              pc_nx = PC_ONE;
            end else begin
              pc_nx = '0;
            end
          end
          RUN: begin
            if (stb) begin
              per_nx = pc;
              vld_nx = 1'b1;
              pc_nx  = PC_ONE;
            end else if (&pc) begin
              of_nx = 1'b1;
              st_nx = ARM;
              pc_nx = '0;
            end else begin
              pc_nx = pc + PC_ONE;
            end
          end
          default: begin
            st_nx = IDLE;
            pc_nx = '0;
          end
        endcase
      end
    end

    assign filtered[i]          = flt;
    assign edge_stb[i]          = stb;
    assign period[PW*i +: PW]   = per;
    assign period_vld[i]        = vld;
    assign ovf[i]               = of;
  end

endmodule

// File: doc/hwag_capture_period.md
Name: hwag_capture_period

Overview:
- Multi-channel successor to the VR input capture stage of the hardware angle generator.
- Each channel has:
  - a 2-FF input synchroniser;
  - a programmable glitch filter;
  - a selectable edge detector (off / rising / falling / both);
  - a period timer that measures clock cycles between consecutive selected edges, with a strobed result and a sticky overflow flag.
- Sits between the VR/hall pins and the tooth-tracking logic. Control values come from the register file.

Parameters:
- CH, 2, number of independent capture channels (1..8).
- FW, 16, filter threshold / filter counter width.
- PW, 24, period counter and result width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low; every output and state register is cleared on the clk edge when rst=0
- ena  in  CH  per-channel enable
- mode  in  2*CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- flt_val  in  CH*FW  per-channel filter threshold, bits [FW*i+FW-1:FW*i]
- ovf_clr  in  CH  per-channel overflow clear
- d  in  CH  raw asynchronous inputs
- filtered  out  CH  filtered level
- edge_stb  out  CH  1-cycle pulse per selected edge
- period  out  CH*PW  last measured period in clk cycles
- period_vld  out  CH  1-cycle pulse when period is updated
- ovf  out  CH  sticky period-counter overflow

Behaviour:
- Reset (rst=0): every output is 0; synchroniser, filter counter, period counter and state are all cleared to 0 / IDLE.
- Synchroniser: d_s is d delayed by 2 FFs.
- Filter, per channel, counter fc:
  - If d_s == filtered: fc <= 0.
  - Else if fc == flt_val: filtered <= d_s and fc <= 0.
  - Else: fc <= fc+1.
  - A level must differ for flt_val+1 consecutive clocks before it is taken.
  - With flt_val=0, filtered follows d_s 1 clock later.
  - Latency from d to filtered is 3+flt_val clocks.
  - flt_val is sampled every cycle; changing it mid-count takes effect immediately.
- ena=0:
  - fc held at 0; filtered holds its value; edge_stb=0.
  - State forced to IDLE and period counter cleared.
  - period and ovf keep their values.
- Edge detect:
  - filtered_q is filtered delayed by 1 clock.
  - rise = filtered & ~filtered_q; fall = ~filtered & filtered_q.
  - edge_stb is registered: high the cycle after filtered_q updates, when (rise & mode[0]) | (fall & mode[1]).
  - mode=00 gives no strobes.
- Period FSM, per channel (states IDLE, ARM, RUN):
  - IDLE: pc=0. Go to ARM when ena=1 and mode!=00.
  - ARM: pc=0. On edge_stb: pc <= 1, go to RUN. No period_vld is issued.
  - RUN, normal counting: pc <= pc+1 each cycle.
  - RUN, on edge_stb: period <= pc, period_vld <= 1 for one cycle, pc <= 1, stay in RUN.
    - For edges at cycles t and t+P, period = P.
    - period_vld rises at t+P+1, coincident with the new period value.
  - RUN, pc == 2^PW-1 with no edge_stb in that cycle: ovf <= 1, go to ARM; period unchanged, no period_vld.
  - RUN, edge_stb in the same cycle pc reaches max: a normal capture of 2^PW-1; no ovf.
  - Any state, ena=0 or mode=00: go to IDLE next cycle; a capture in progress is discarded.
- ovf_clr: ovf <= 0. If ovf_clr and an overflow set occur in the same cycle, set wins.
- Channels are fully independent. There is no cross-channel arbitration.
- Reset mid-operation: everything returns to reset values on the next clk edge; pending pulses are dropped.

Test Plan:
1. Reset and idle:
   - Stimulus: rst=0 for 4 clocks with d toggling.
   - Required: all outputs 0. After release with ena=0, no edge_stb and no period_vld.
2. Glitch filter, CH0 with flt_val=3:
   - Stimulus: a 3-clock high pulse on d, then a 10-clock high pulse.
   - Required: the 3-clock pulse is rejected (filtered stays 0). For the 10-clock pulse, filtered rises exactly 6 clocks after d rises.
3. Rising-edge period:
   - Setup: mode=01, flt_val=0.
   - Stimulus: filtered rising edges every 100 clocks, 4 times.
   - Required: the first edge produces no period_vld. Then 3 period_vld pulses, each with period=100, one clock after each edge_stb.
4. Both-edge mode:
   - Setup: mode=11.
   - Stimulus: square wave, high 30 / low 70.
   - Required: periods alternate 30, 70; edge_stb occurs on every transition.
5. Overflow and recovery:
   - Setup: PW=8.
   - Stimulus: one edge, then 300 idle clocks.
   - Required: ovf=1 at pc=255, with no period_vld.
   - Next two edges 50 apart: the first only re-arms, the second gives period=50.
   - ovf stays 1 until ovf_clr is pulsed; then ovf=0.
   - ovf_clr asserted in the same cycle as an overflow leaves ovf=1.
6. Channel independence and disable:
   - Stimulus: CH0 at period 40 and CH1 at period 64 concurrently; then ena[1]=0 mid-RUN.
   - Required: CH0 keeps reporting 40. CH1 stops, keeping its last period=64.
   - After re-enable, CH1's first edge produces no period_vld.
